bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits directly upstream of the per-digit BCD-to-7-segment decoders. Takes a binary count and produces DIGITS packed 4-bit BCD digits, which feed one decoder each. Uses a start/done handshake, so the display only updates with complete results.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_add3.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 130 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, special digit codes and the digit-range helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_NINE  = 4'h9;

    // Largest value representable with the given number of decimal digits.
    function automatic longint unsigned bcd_max(input int unsigned digits);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust cell: digits of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    always_comb begin
        adj_c = digit;
        if (digit >= 4'd5) begin
            adj_c = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional macro BLANK_LEAD_EN replaces leading zero digits with 4'hF.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CAT_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = bcd_max(DIGITS);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    sh_q, sh_d;
    logic [BCD_W-1:0]    work_q, work_d;
    logic                pend_q, pend_d;
    logic                busy_d, done_d, ovf_d;
    logic [BCD_W-1:0]    bcd_d;

    logic [BCD_W-1:0]    adj_c;
    logic [CAT_W-1:0]    shl_c;
    logic [BCD_W-1:0]    res_c;
    logic                ovf_c;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (work_q[4*g +: 4]),
            .adj_c (adj_c[4*g +: 4])
        );
    end

    assign shl_c = {adj_c, sh_q} << 1;
    assign ovf_c = 64'(bin) > MAX_VAL;

    // Final digits as presented at DONE, with optional leading-zero blanking.
    always_comb begin
        res_c = shl_c[BIN_W +: BCD_W];
`ifdef BLANK_LEAD_EN
        begin : blank_lead
            logic lead;
            lead = 1'b1;
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                if (lead && (res_c[4*i +: 4] == 4'h0)) begin
                    res_c[4*i +: 4] = BCD_BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        work_d  = work_q;
        pend_d  = pend_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        bcd_d   = bcd;
        ovf_d   = overflow;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    sh_d    = bin;
                    work_d  = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    pend_d  = ovf_c;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                sh_d   = shl_c[BIN_W-1:0];
                work_d = shl_c[BIN_W +: BCD_W];
                cnt_d  = cnt_q - CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = pend_q;
                    bcd_d   = pend_q ? {DIGITS{BCD_NINE}} : res_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            work_q   <= '0;
            pend_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            work_q   <= work_d;
            pend_q   <= pend_d;
            busy     <= busy_d;
            done     <= done_d;
            bcd      <= bcd_d;
            overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: table vectors, corner sequences
// and random values checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int unsigned BIN_W  = 14;
    localparam int unsigned DIGITS = 4;
    localparam int LAT = 14;

    logic              clk;
    logic              reset;
    logic              start;
    logic [BIN_W-1:0]  bin;
    logic              busy;
    logic              done;
    logic [15:0]       bcd;
    logic              overflow;

    int errors;
    int checks;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t tbl[8];

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] blank(input logic [15:0] r);
        logic [15:0] o;
        o = r;
`ifdef BLANK_LEAD_EN
        for (int i = 3; i >= 1; i--) begin
            if (o[4*i +: 4] != 4'h0) break;
            o[4*i +: 4] = 4'hF;
        end
`endif
        return o;
    endfunction

    function automatic logic [15:0] model(input int v);
        logic [15:0] r;
        int x;
        if (v > 9999) return 16'h9999;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return blank(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where done should rise.
    task automatic run_conv(input logic [13:0] b, input int glitch_k,
                            output logic [15:0] got, output logic ovf);
        logic [15:0] prev;
        int bad;
        bad = 0;
        prev = bcd;
        start = 1'b1;
        bin = b;
        @(posedge clk); #1;
        start = 1'b0;
        bin = 14'($urandom);
        if (busy !== 1'b1 || done !== 1'b0 || bcd !== prev) bad++;
        for (int k = 1; k <= LAT; k++) begin
            if (k == glitch_k) begin
                start = 1'b1;
                bin = 14'd777;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (k < LAT && (busy !== 1'b1 || done !== 1'b0 || bcd !== prev)) bad++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latency bin=%0d: done=%b busy=%b, required done=1 busy=0", b, done, busy);
        end
        chk("busy_hold_during_shift", 32'(bad), 32'd0);
        got = bcd;
        ovf = overflow;
    endtask

    task automatic idle_cycle(input logic [15:0] exp_bcd);
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_single_pulse", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("bcd_hold", 32'(bcd), 32'(exp_bcd));
    endtask

    initial begin
        logic [15:0] got;
        logic ovf;
        int v;

        errors = 0;
        checks = 0;
        tbl[0] = '{14'd1234,  16'h1234, 1'b0};
        tbl[1] = '{14'd5,     16'h0005, 1'b0};
        tbl[2] = '{14'd80,    16'h0080, 1'b0};
        tbl[3] = '{14'd9999,  16'h9999, 1'b0};
        tbl[4] = '{14'd0,     16'h0000, 1'b0};
        tbl[5] = '{14'd10000, 16'h9999, 1'b1};
        tbl[6] = '{14'd5858,  16'h5858, 1'b0};
        tbl[7] = '{14'd16383, 16'h9999, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        bin = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_bcd", 32'(bcd), 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // First conversion after reset.
        run_conv(14'd1234, 0, got, ovf);
        chk("bcd_1234", 32'(got), 32'(blank(16'h1234)));
        chk("ovf_1234", {31'd0, ovf}, 32'd0);
        idle_cycle(got);

        // Back-to-back: second start issued during the DONE cycle.
        run_conv(14'd9999, 0, got, ovf);
        chk("bcd_9999", 32'(got), 32'h9999);
        run_conv(14'd0, 0, got, ovf);
        chk("bcd_zero_b2b", 32'(got), 32'(blank(16'h0000)));
        chk("ovf_zero_b2b", {31'd0, ovf}, 32'd0);
        idle_cycle(got);

        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].bin, 0, got, ovf);
            chk($sformatf("tbl%0d_bcd", i), 32'(got), 32'(blank(tbl[i].bcd)));
            chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ovf});
            idle_cycle(got);
        end

        // Start pulsed mid-conversion must be ignored.
        run_conv(14'd2500, 5, got, ovf);
        chk("glitch_bcd", 32'(got), 32'(model(2500)));
        idle_cycle(got);

        // Overflow set, then reset at SHIFT cycle 7.
        run_conv(14'd16383, 0, got, ovf);
        chk("pre_reset_ovf", {31'd0, ovf}, 32'd1);
        idle_cycle(got);
        start = 1'b1;
        bin = 14'd3000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_bcd", 32'(bcd), 32'd0);
        chk("midreset_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("after_reset_busy", {31'd0, busy}, 32'd0);
        run_conv(14'd42, 0, got, ovf);
        chk("bcd_42", 32'(got), 32'(blank(16'h0042)));
        chk("ovf_42", {31'd0, ovf}, 32'd0);
        idle_cycle(got);

        // Random values, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            v = (i % 5 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
            run_conv(14'(v), 0, got, ovf);
            chk($sformatf("rand_bcd v=%0d", v), 32'(got), 32'(model(v)));
            chk($sformatf("rand_ovf v=%0d", v), {31'd0, ovf}, (v > 9999) ? 32'd1 : 32'd0);
            if ($urandom_range(0, 1) == 0) idle_cycle(got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
